// File: rtl/pong_pkg.sv
// Shared constants for the pong collision/score logic: default screen geometry,
// band widths, score limit and the bit positions of the per-frame event vector.
package pong_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_EDGE_PX   = 3;
    localparam int DEF_SCORE_MAX = 9;

    localparam int SCORE_W = 4;
    localparam int N_EVT   = 5;

    // Bit positions inside an event vector
    localparam int WALL   = 0;
    localparam int PAD_L  = 1;
    localparam int PAD_R  = 2;
    localparam int GOAL_L = 3;
    localparam int GOAL_R = 4;

    typedef logic [N_EVT-1:0]   evt_t;
    typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/score_counter.sv
// One player's score: counts rising edges of the published goal flag,
// saturating at SCORE_MAX. at_max_o is a plain compare of the held score.
module score_counter
    import pong_pkg::*;
#(
    parameter int SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               publish_i,
    input  logic               goal_i,
    output logic [SCORE_W-1:0] score_o,
    output logic               at_max_o
);

    localparam score_t MAX_C = SCORE_W'(SCORE_MAX);

    score_t score_q, score_d;
    logic   goal_prev_q, goal_prev_d;

    // A goal held over several frames (ball parked in the goal) scores once.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        score_d     = score_q;
        goal_prev_d = goal_prev_q;
        if (publish_i) begin
            goal_prev_d = goal_i;
            if (goal_i && !goal_prev_q && (score_q < MAX_C)) begin
                score_d = score_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            score_q     <= '0;
            goal_prev_q <= 1'b0;
        end else begin
            score_q     <= score_d;
            goal_prev_q <= goal_prev_d;
        end
    end

    assign score_o  = score_q;
    assign at_max_o = (score_q == MAX_C);

endmodule

// File: rtl/collision_detect.sv
// Frame-level collision detector: classifies registered pixel coincidences,
// accumulates sticky events over the frame and publishes them once per frame.
module collision_detect
    import pong_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int EDGE_PX   = DEF_EDGE_PX,
    parameter int SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       ball_px,
    input  logic       paddle_l_px,
    input  logic       paddle_r_px,
    output logic       collision,
    output logic       hit_wall,
    output logic       hit_paddle_l,
    output logic       hit_paddle_r,
    output logic       goal_l,
    output logic       goal_r,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over
);

    localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM    = 10'(V_ACTIVE);
    localparam logic [9:0] EDGE_C   = 10'(EDGE_PX);
    localparam logic [9:0] H_GOAL_R = 10'(H_ACTIVE - EDGE_PX);
    localparam logic [9:0] V_WALL_B = 10'(V_ACTIVE - EDGE_PX);

    // hcount/vcount delayed one cycle so they line up with the pixel inputs
    logic [9:0] hc_q, vc_q;

    evt_t acc_q, acc_d;
    evt_t flags_q, flags_d;
    evt_t evt_now;
    logic collision_q, collision_d;
    logic game_over_q, game_over_d;
    logic active, publish;
    logic p1_at_max, p2_at_max;

    assign active  = (hc_q < H_LIM) && (vc_q < V_LIM);
    // First front-porch line: outside active video, so no event can coincide.
    assign publish = (vc_q == V_LIM) && (hc_q == 10'd0);

    always_comb begin
        evt_now = '0;
        if (active && ball_px) begin
            evt_now[WALL]   = (vc_q < EDGE_C) || (vc_q >= V_WALL_B);
            evt_now[PAD_L]  = paddle_l_px;
            evt_now[PAD_R]  = paddle_r_px;
            evt_now[GOAL_L] = (hc_q < EDGE_C);
            evt_now[GOAL_R] = (hc_q >= H_GOAL_R);
        end
    end

    always_comb begin
        acc_d       = acc_q | evt_now;
        flags_d     = flags_q;
        collision_d = collision_q;
        if (publish) begin
            flags_d     = acc_q;
            collision_d = |acc_q;
            acc_d       = '0;
        end
    end

    assign game_over_d = p1_at_max | p2_at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q        <= '0;
            vc_q        <= '0;
            acc_q       <= '0;
            flags_q     <= '0;
            collision_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            hc_q        <= hcount;
            vc_q        <= vcount;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            collision_q <= collision_d;
            game_over_q <= game_over_d;
        end
    end

    // p1 is credited for the ball reaching the right goal, p2 for the left.
    score_counter #(
        .SCORE_MAX (SCORE_MAX)
    ) u_score_p1 (
        .clk       (clk),
        .reset     (reset),
        .publish_i (publish),
        .goal_i    (acc_q[GOAL_R]),
        .score_o   (score_p1),
        .at_max_o  (p1_at_max)
    );

    score_counter #(
        .SCORE_MAX (SCORE_MAX)
    ) u_score_p2 (
        .clk       (clk),
        .reset     (reset),
        .publish_i (publish),
        .goal_i    (acc_q[GOAL_L]),
        .score_o   (score_p2),
        .at_max_o  (p2_at_max)
    );

    assign collision    = collision_q;
    assign hit_wall     = flags_q[WALL];
    assign hit_paddle_l = flags_q[PAD_L];
    assign hit_paddle_r = flags_q[PAD_R];
    assign goal_l       = flags_q[GOAL_L];
    assign goal_r       = flags_q[GOAL_R];
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_collision_detect.sv
// Bench for collision_detect: sparse coordinate sequences stand in for frames,
// checked against a frame-level model of the event, publish and score rules.
module tb_collision_detect;

    localparam int H    = 640;
    localparam int V    = 480;
    localparam int E    = 3;
    localparam int SMAX = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hcount, vcount;
    logic       ball_px, paddle_l_px, paddle_r_px;
    logic       collision, hit_wall, hit_paddle_l, hit_paddle_r, goal_l, goal_r;
    logic [3:0] score_p1, score_p2;
    logic       game_over;

    collision_detect dut (
        .clk          (clk),
        .reset        (reset),
        .hcount       (hcount),
        .vcount       (vcount),
        .ball_px      (ball_px),
        .paddle_l_px  (paddle_l_px),
        .paddle_r_px  (paddle_r_px),
        .collision    (collision),
        .hit_wall     (hit_wall),
        .hit_paddle_l (hit_paddle_l),
        .hit_paddle_r (hit_paddle_r),
        .goal_l       (goal_l),
        .goal_r       (goal_r),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: events seen this frame, last published set, scores.
    bit       m_wall, m_pl, m_pr, m_gl, m_gr;
    bit [5:0] m_pub;   // {collision, wall, pad_l, pad_r, goal_l, goal_r}
    int       m_s1, m_s2;
    bit [2:0] pend;    // pixel bits owed to the coordinate driven last cycle

    function automatic void model_clear_frame();
        m_wall = 0; m_pl = 0; m_pr = 0; m_gl = 0; m_gr = 0;
    endfunction

    function automatic void model_reset();
        model_clear_frame();
        m_pub = '0;
        m_s1  = 0;
        m_s2  = 0;
    endfunction

    function automatic void model_pixel(input int h, input int v, input bit b, input bit l, input bit r);
        if (b && h < H && v < V) begin
            if (v < E || v >= V - E) m_wall = 1;
            if (l) m_pl = 1;
            if (r) m_pr = 1;
            if (h < E) m_gl = 1;
            if (h >= H - E) m_gr = 1;
        end
    endfunction

    function automatic void model_publish();
        if (m_gr && !m_pub[0] && m_s1 < SMAX) m_s1++;
        if (m_gl && !m_pub[1] && m_s2 < SMAX) m_s2++;
        m_pub = {m_wall | m_pl | m_pr | m_gl | m_gr, m_wall, m_pl, m_pr, m_gl, m_gr};
        model_clear_frame();
    endfunction

    // Present a coordinate now; its pixel bits follow one cycle later.
    task automatic drive(input int h, input int v, input bit b, input bit l, input bit r);
        @(negedge clk);
        hcount = 10'(h);
        vcount = 10'(v);
        {ball_px, paddle_l_px, paddle_r_px} = pend;
        pend = {b, l, r};
        model_pixel(h, v, b, l, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        hcount = '0;
        vcount = '0;
        {ball_px, paddle_l_px, paddle_r_px} = 3'b000;
        pend = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 32'({collision, hit_wall, hit_paddle_l, hit_paddle_r, goal_l, goal_r}), 32'd0);
        check({tag, "_scores"}, 32'({score_p1, score_p2}), 32'd0);
        check({tag, "_game_over"}, 32'(game_over), 32'd0);
    endtask

    // Walk through the publish coordinate and compare against the model.
    task automatic publish_check(input string tag);
        drive(0, V, 0, 0, 0);
        drive(1, V, 0, 0, 0);
        model_publish();
        drive(2, V, 0, 0, 0);
        check({tag, "_flags"}, 32'({collision, hit_wall, hit_paddle_l, hit_paddle_r, goal_l, goal_r}), 32'(m_pub));
        check({tag, "_score_p1"}, 32'(score_p1), 32'(m_s1));
        check({tag, "_score_p2"}, 32'(score_p2), 32'(m_s2));
        drive(3, V, 0, 0, 0);
        check({tag, "_game_over"}, 32'(game_over), 32'(m_s1 == SMAX || m_s2 == SMAX));
    endtask

    function automatic int pick_h();
        case ($urandom_range(0, 4))
            0:       return int'($urandom_range(0, E));
            1:       return int'($urandom_range(H - E - 1, H));
            2:       return int'($urandom_range(0, 799));
            default: return int'($urandom_range(0, H - 1));
        endcase
    endfunction

    function automatic int pick_v();
        case ($urandom_range(0, 4))
            0:       return int'($urandom_range(0, E));
            1:       return int'($urandom_range(V - E - 1, V));
            2:       return int'($urandom_range(0, 524));
            default: return int'($urandom_range(0, V - 1));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        hcount = '0;
        vcount = '0;
        {ball_px, paddle_l_px, paddle_r_px} = 3'b000;
        pend = 3'b000;
        model_reset();

        do_reset();
        check_all_zero("reset");

        // Wall hit on line 1, then a quiet frame clears everything.
        drive(320, 1, 1, 0, 0);
        publish_check("wall");
        check("wall_hit", 32'(hit_wall), 32'd1);
        check("wall_collision", 32'(collision), 32'd1);
        publish_check("quiet");
        check("quiet_collision", 32'(collision), 32'd0);

        // Left paddle hit held through the vsync falling edge.
        drive(30, 200, 1, 1, 0);
        publish_check("pad_l");
        check("pad_l_hit", 32'({hit_paddle_l, hit_paddle_r, collision}), 32'b101);
        for (int v = 481; v <= 492; v++) begin
            drive(0, v, 0, 0, 0);
            check("pad_l_hold", 32'({hit_paddle_l, collision}), 32'b11);
        end

        // Right paddle alone; paddle pixel without ball counts for nothing.
        drive(500, 300, 1, 0, 1);
        drive(100, 300, 0, 1, 1);
        publish_check("pad_r");
        check("pad_r_hit", 32'({hit_paddle_l, hit_paddle_r}), 32'b01);

        // Ball parked in the right goal for five frames scores once.
        for (int f = 0; f < 5; f++) begin
            drive(638, 240, 1, 0, 0);
            publish_check("goal_r_hold");
            check("goal_r_flag", 32'(goal_r), 32'd1);
        end
        check("goal_r_once", 32'(score_p1), 32'd1);

        // Ten separate episodes saturate the score at the limit.
        for (int ep = 0; ep < 10; ep++) begin
            publish_check("gap");
            drive(638, 240, 1, 0, 0);
            publish_check("episode");
        end
        check("sat_score", 32'(score_p1), 32'(SMAX));
        check("sat_game_over", 32'(game_over), 32'd1);

        // Ball in horizontal blanking is ignored.
        drive(700, 200, 1, 1, 1);
        publish_check("blank");
        check("blank_flags", 32'({collision, hit_wall, hit_paddle_l, hit_paddle_r, goal_l, goal_r}), 32'd0);

        // Reset mid-frame discards the earlier wall hit.
        drive(320, 1, 1, 0, 0);
        drive(5, 100, 0, 0, 0);
        do_reset();
        publish_check("midreset");
        check("midreset_collision", 32'(collision), 32'd0);
        check("midreset_scores", 32'({score_p1, score_p2}), 32'd0);

        // Both goals in one frame credit both players.
        drive(1, 240, 1, 0, 0);
        drive(639, 240, 1, 0, 0);
        publish_check("both_goals");
        check("both_scores", 32'({score_p1, score_p2}), 32'h11);

        // Reset landing on the publish cycle wins.
        drive(320, 1, 1, 0, 0);
        drive(0, V, 0, 0, 0);
        do_reset();
        check_all_zero("reset_vs_publish");
        publish_check("after_reset_publish");

        // Randomized frames with a reset in the middle.
        for (int f = 0; f < 40; f++) begin
            int n;
            n = int'($urandom_range(4, 12));
            for (int p = 0; p < n; p++) begin
                int h, v;
                bit b, l, r;
                h = pick_h();
                v = pick_v();
                if (h == 0 && v == V) h = 1;
                b = ($urandom_range(0, 3) == 0);
                l = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 2) == 0);
                drive(h, v, b, l, r);
            end
            publish_check("rand");
            if (f == 20) begin
                do_reset();
                check_all_zero("rand_reset");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_detect.md
COLLISION_DETECT -- requirements
Module: collision_detect

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 Parameter EDGE_PX, default 3: width in pixels of the wall band and the goal band.
REQ-004 Parameter SCORE_MAX, default 9: saturation value of each score counter.
REQ-005 clk  in  1: single system/pixel clock; all logic on posedge clk.
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 hcount  in  10: current horizontal pixel counter from VGA timing.
REQ-008 vcount  in  10: current vertical line counter from VGA timing.
REQ-009 ball_px  in  1: registered ball pixel; high when the ball is drawn at the previous cycle's hcount/vcount.
REQ-010 paddle_l_px  in  1: registered left-paddle pixel, same one-cycle alignment as ball_px.
REQ-011 paddle_r_px  in  1: registered right-paddle pixel, same alignment.
REQ-012 collision  out  1: frame-level collision flag consumed by the ball at the falling edge of vsync.
REQ-013 hit_wall, hit_paddle_l, hit_paddle_r, goal_l, goal_r  out  1 each: published per-frame event flags.
REQ-014 score_p1, score_p2  out  4 each: player scores; p1 scores on goal_r, p2 scores on goal_l.
REQ-015 game_over  out  1: high when either score equals SCORE_MAX.

Function
REQ-016 Register hcount/vcount by one cycle (hc_d, vc_d) and use hc_d/vc_d for all pixel classification, to align with the registered pixel inputs.
REQ-017 Classify pixels only when hc_d < H_ACTIVE and vc_d < V_ACTIVE; ignore all pixel inputs outside that region.
REQ-018 Wall event: ball_px high and (vc_d < EDGE_PX or vc_d >= V_ACTIVE-EDGE_PX).
REQ-019 Paddle events: ball_px and paddle_l_px both high sets the left paddle event; ball_px and paddle_r_px both high sets the right paddle event.
REQ-020 Goal events: ball_px high and hc_d < EDGE_PX sets goal_l; ball_px high and hc_d >= H_ACTIVE-EDGE_PX sets goal_r.
REQ-021 Each event sets a sticky accumulator bit; the bit stays set until the publish cycle.
REQ-022 Publish cycle: the cycle where vc_d == V_ACTIVE and hc_d == 0, i.e. first front-porch line, strictly before vsync falls.
REQ-023 On publish, copy accumulators to the outputs in REQ-013, set collision to the OR of all five, and clear all accumulators in the same cycle.
REQ-024 An event on the same cycle as publish is not possible, because the region is outside active video; no merge logic is required.
REQ-025 Published flags hold for exactly one frame, until the next publish, so the flags are stable across the vsync falling edge.
REQ-026 Scoring: on publish, if the new goal_r is 1 and the previous published goal_r was 0, increment score_p1; goal_l does the same for score_p2.
REQ-027 Because the ball halts after a goal, repeated goal frames add exactly one point.
REQ-028 Scores saturate at SCORE_MAX; further goals leave them unchanged.
REQ-029 game_over is registered and updates in the cycle after the score changes.
REQ-030 Simultaneous goal_l and goal_r in one frame increment both scores.

Reset
REQ-031 On reset, all accumulators, published flags, collision, scores, game_over and hc_d/vc_d are 0.
REQ-032 Reset mid-frame discards that frame's accumulated events; the next publish reports only events seen after reset deasserts.
REQ-033 Reset takes priority over the publish cycle and over score updates.

Structure
REQ-034 Place H_ACTIVE/V_ACTIVE defaults, EDGE_PX, SCORE_MAX and the event-bit index constants (WALL, PAD_L, PAD_R, GOAL_L, GOAL_R) in the shared package pong_pkg.
REQ-035 Implement each player score as one instance of the sub-module score_counter, with rising-edge detect and saturating count.
REQ-036 Pixel classification and the accumulators stay in collision_detect.

Verification
REQ-037 Ball pixel at (hc_d=320, vc_d=1) in frame N -> at publish of frame N: hit_wall=1, collision=1; at publish of frame N+1 with no events: all 0.
REQ-038 ball_px and paddle_l_px coincident at (30,200) -> hit_paddle_l=1, hit_paddle_r=0, collision=1; flag held constant from publish through the vsync falling edge.
REQ-039 Ball pixel at hc_d=638 for 5 consecutive frames -> goal_r=1 every frame, score_p1 increments 0->1 exactly once.
REQ-040 Ten separate goal_r episodes, each separated by a goal-free frame -> score_p1 reaches 9, game_over=1, score_p1 stays 9.
REQ-041 Assert reset at vc_d=100 after a wall hit at line 1, release, no further events -> next publish: collision=0, scores 0.
REQ-042 ball_px high at hc_d=700 (blanking) -> no flags set at publish.
